// File: rtl/fmps_link_pkg.sv
// Shared constants for the FMPS test-link receiver: status codes, framing FSM
// encoding and default header field layout.
package fmps_link_pkg;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_BAD_MAGIC = 2'd1;
    localparam logic [1:0] ST_SHORT     = 2'd2;
    localparam logic [1:0] ST_LONG      = 2'd3;

    localparam logic [1:0] S_HEADER = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam int DEF_MAGIC_WIDTH     = 16;
    localparam int DEF_MAGIC_START_BIT = 16;
    localparam int DEF_INDEX_WIDTH     = 5;
    localparam int DEF_INDEX_START_BIT = 10;
    localparam int DEF_NUM_DATA_WORDS  = 1;

    // Word counter is sized for the largest supported packet (8 data beats).
    localparam int CNT_W = 4;

endpackage

// File: rtl/fmps_cycle_tally.sv
// Per-FA-cycle tally of good packets: saturating count plus index bitmap,
// snapshotted and cleared on every cycle boundary.
module fmps_cycle_tally
    import fmps_link_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_newCycle,
    input  logic                        i_pktStrobe,
    input  logic [INDEX_WIDTH-1:0]      i_pktIndex,
    output logic                        o_cycleStrobe,
    output logic [INDEX_WIDTH:0]        o_count,
    output logic [2**INDEX_WIDTH-1:0]   o_map
);

    localparam int MAP_W = 2**INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0] CNT_MAX = '1;

    logic [INDEX_WIDTH:0] r_count;
    logic [MAP_W-1:0]     r_map;
    logic [INDEX_WIDTH:0] w_inc;
    logic [MAP_W-1:0]     w_hit;

    assign w_inc = (r_count == CNT_MAX) ? r_count : r_count + {{INDEX_WIDTH{1'b0}}, 1'b1};
    assign w_hit = i_pktStrobe ? (MAP_W'(1) << i_pktIndex) : '0;

    // A strobe arriving with the boundary belongs to a TLAST accepted in the
    // closing cycle, so it is folded into the snapshot rather than the new cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_map         <= '0;
            o_cycleStrobe <= 1'b0;
            o_count       <= '0;
            o_map         <= '0;
        end else begin
            o_cycleStrobe <= i_newCycle;
            if (i_newCycle) begin
                o_count <= i_pktStrobe ? w_inc : r_count;
                o_map   <= r_map | w_hit;
                r_count <= '0;
                r_map   <= '0;
            end else if (i_pktStrobe) begin
                r_count <= w_inc;
                r_map   <= r_map | w_hit;
            end
        end
    end

endmodule

// File: rtl/fmps_link_rx.sv
// FMPS test-link receiver: checks header/data framing of the AXI-Stream,
// reports one status per packet and delivers good packets with a cycle tally.
module fmps_link_rx
    import fmps_link_pkg::*;
#(
    parameter int MAGIC_WIDTH     = DEF_MAGIC_WIDTH,
    parameter int MAGIC_START_BIT = DEF_MAGIC_START_BIT,
    parameter int INDEX_WIDTH     = DEF_INDEX_WIDTH,
    parameter int INDEX_START_BIT = DEF_INDEX_START_BIT,
    parameter int NUM_DATA_WORDS  = DEF_NUM_DATA_WORDS
) (
    input  logic                           auroraUserClk,
    input  logic                           auroraReset_n,
    input  logic                           newCycleStrobe,
    input  logic [MAGIC_WIDTH-1:0]         expectedHeaderMagic,
    input  logic                           TVALID,
    input  logic                           TLAST,
    input  logic [31:0]                    TDATA,
    output logic                           TREADY,
    output logic                           statusStrobe,
    output logic [1:0]                     statusCode,
    output logic                           packetStrobe,
    output logic [INDEX_WIDTH-1:0]         packetIndex,
    output logic [32*NUM_DATA_WORDS-1:0]   packetData,
    output logic                           cycleStrobe,
    output logic [INDEX_WIDTH:0]           cyclePacketCount,
    output logic [2**INDEX_WIDTH-1:0]      cycleIndexMap
);

    logic [1:0]                           r_state;
    logic [CNT_W-1:0]                     r_count;
    logic [INDEX_WIDTH-1:0]               r_index;
    logic [NUM_DATA_WORDS-1:0][31:0]      r_buf;
    logic                                 r_tready;
    logic                                 r_statusStrobe;
    logic [1:0]                           r_statusCode;
    logic                                 r_packetStrobe;
    logic [INDEX_WIDTH-1:0]               r_packetIndex;
    logic [NUM_DATA_WORDS-1:0][31:0]      r_packetData;

    logic                                 w_accept;
    logic                                 w_magicOk;
    logic [CNT_W-1:0]                     w_cntNext;
    logic                                 w_full;
    logic [NUM_DATA_WORDS-1:0][31:0]      w_nextBuf;

    assign w_accept  = TVALID && r_tready;
    assign w_magicOk = (TDATA[MAGIC_START_BIT +: MAGIC_WIDTH] == expectedHeaderMagic);
    assign w_cntNext = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_full    = (w_cntNext == CNT_W'(NUM_DATA_WORDS));

    // Buffer view including the beat being accepted, so the final word can be
    // delivered in the same edge that stores it.
    always_comb begin
        w_nextBuf = r_buf;
        for (int i = 0; i < NUM_DATA_WORDS; i++) begin
            if (r_count == CNT_W'(i)) w_nextBuf[i] = TDATA;
        end
    end

    always_ff @(posedge auroraUserClk) begin
        if (!auroraReset_n) begin
            r_state        <= S_HEADER;
            r_count        <= '0;
            r_index        <= '0;
            r_buf          <= '0;
            r_tready       <= 1'b0;
            r_statusStrobe <= 1'b0;
            r_statusCode   <= ST_OK;
            r_packetStrobe <= 1'b0;
            r_packetIndex  <= '0;
            r_packetData   <= '0;
        end else begin
            r_tready       <= 1'b1;
            r_statusStrobe <= 1'b0;
            r_packetStrobe <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_HEADER: begin
                        r_index <= TDATA[INDEX_START_BIT +: INDEX_WIDTH];
                        if (!w_magicOk) begin
                            r_statusStrobe <= 1'b1;
                            r_statusCode   <= ST_BAD_MAGIC;
                            r_state        <= TLAST ? S_HEADER : S_DRAIN;
                        end else if (TLAST) begin
                            r_statusStrobe <= 1'b1;
                            r_statusCode   <= ST_SHORT;
                        end else begin
                            r_state <= S_DATA;
                            r_count <= '0;
                        end
                    end
                    S_DATA: begin
                        r_buf   <= w_nextBuf;
                        r_count <= w_cntNext;
                        if (TLAST) begin
                            r_state        <= S_HEADER;
                            r_statusStrobe <= 1'b1;
                            if (w_full) begin
                                r_statusCode   <= ST_OK;
                                r_packetStrobe <= 1'b1;
                                r_packetIndex  <= r_index;
                                r_packetData   <= w_nextBuf;
                            end else begin
                                r_statusCode <= ST_SHORT;
                            end
                        end else if (w_full) begin
                            r_statusStrobe <= 1'b1;
                            r_statusCode   <= ST_LONG;
                            r_state        <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (TLAST) r_state <= S_HEADER;
                    end
                    default: r_state <= S_HEADER;
                endcase
            end
        end
    end

    assign TREADY       = r_tready;
    assign statusStrobe = r_statusStrobe;
    assign statusCode   = r_statusCode;
    assign packetStrobe = r_packetStrobe;
    assign packetIndex  = r_packetIndex;
    assign packetData   = r_packetData;

    fmps_cycle_tally #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_tally (
        .clk           (auroraUserClk),
        .rst_n         (auroraReset_n),
        .i_newCycle    (newCycleStrobe),
        .i_pktStrobe   (r_packetStrobe),
        .i_pktIndex    (r_packetIndex),
        .o_cycleStrobe (cycleStrobe),
        .o_count       (cyclePacketCount),
        .o_map         (cycleIndexMap)
    );

endmodule

// File: tb/tb_fmps_link_rx.sv
// Self-checking bench for fmps_link_rx: table of framing cases, hand-built
// cycle-boundary and reset sequences, and a randomized gap run.
module tb_fmps_link_rx;
    import fmps_link_pkg::*;

    localparam int N = 1;
    localparam logic [15:0] MAGIC = 16'hB6CF;

    logic        clk = 1'b0;
    logic        rst_n, nc, tvalid, tlast;
    logic [31:0] tdata;
    logic [15:0] magic;
    logic        tready, statusStrobe, packetStrobe, cycleStrobe;
    logic [1:0]  statusCode;
    logic [4:0]  packetIndex;
    logic [31:0] packetData;
    logic [5:0]  cyclePacketCount;
    logic [31:0] cycleIndexMap;

    always #5 clk = ~clk;

    fmps_link_rx dut (
        .auroraUserClk       (clk),
        .auroraReset_n       (rst_n),
        .newCycleStrobe      (nc),
        .expectedHeaderMagic (magic),
        .TVALID              (tvalid),
        .TLAST               (tlast),
        .TDATA               (tdata),
        .TREADY              (tready),
        .statusStrobe        (statusStrobe),
        .statusCode          (statusCode),
        .packetStrobe        (packetStrobe),
        .packetIndex         (packetIndex),
        .packetData          (packetData),
        .cycleStrobe         (cycleStrobe),
        .cyclePacketCount    (cyclePacketCount),
        .cycleIndexMap       (cycleIndexMap)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int cyc; logic [1:0] code; logic [4:0] idx; logic [31:0] data; } st_exp_t;
    typedef struct { int cyc; int cnt; logic [31:0] map; } cy_exp_t;
    typedef struct { logic [31:0] hdr; int ndata; logic [31:0] d0; logic [1:0] code; logic [4:0] idx; } vec_t;

    st_exp_t sq[$];
    cy_exp_t cq[$];
    st_exp_t e;
    cy_exp_t ce;

    // Reference tally: counts good packets by the cycle in which their TLAST beat is accepted.
    int          m_cnt = 0;
    logic [31:0] m_map = '0;
    bit          nc_pending = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: apply the pending boundary, update the model, advance to #1 after the edge.
    task automatic step(input bit good_end, input logic [4:0] idx, output bit acc);
        nc = nc_pending;
        nc_pending = 0;
        if (nc) begin
            cq.push_back('{cyc + 1, m_cnt, m_map});
            m_cnt = 0;
            m_map = '0;
        end
        acc = tvalid && tready;
        if (acc && good_end) begin
            if (m_cnt < 63) m_cnt++;
            m_map[idx] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        tvalid = 0;
        tlast  = 0;
        for (int i = 0; i < n; i++) step(0, 5'd0, a);
    endtask

    // Status is expected after the beat that terminates the packet: the header on
    // a bad magic, otherwise the TLAST beat or the Nth data beat, whichever is first.
    task automatic send_packet(input logic [31:0] hdr, input int ndata, input logic [31:0] d0,
                               input logic [1:0] code, input logic [4:0] idx,
                               input int gap_pct, input bit nc_at_last);
        int nb   = ndata + 1;
        bit bad  = (hdr[31:16] != MAGIC);
        int term = bad ? 0 : ((ndata < N) ? ndata : N);
        for (int b = 0; b < nb; b++) begin
            bit acc   = 0;
            int tries = 0;
            tdata = (b == 0) ? hdr : ((b == 1) ? d0 : $urandom());
            tlast = (b == nb - 1);
            if (nc_at_last && tlast) nc_pending = 1;
            while (!acc) begin
                if (tries > 200) begin
                    chk("accept_timeout", 64'd0, 64'd1);
                    tvalid = 0;
                    return;
                end
                tvalid = ($urandom_range(0, 99) >= gap_pct);
                if (tvalid && tready && b == term) sq.push_back('{cyc + 1, code, idx, d0});
                step(tvalid && tlast && (code == ST_OK), idx, acc);
                tries++;
            end
        end
        tvalid = 0;
        tlast  = 0;
    endtask

    always @(negedge clk) begin
        if (statusStrobe) begin
            if (sq.size() == 0) begin
                chk("spurious_status", {62'd0, statusCode}, 64'hFF);
            end else begin
                e = sq.pop_front();
                chk("status_time", 64'(cyc), 64'(e.cyc));
                chk("status_code", 64'(statusCode), 64'(e.code));
                chk("packet_strobe", 64'(packetStrobe), 64'(e.code == ST_OK));
                if (e.code == ST_OK) begin
                    chk("packet_index", 64'(packetIndex), 64'(e.idx));
                    chk("packet_data", 64'(packetData), 64'(e.data));
                end
            end
        end else if (packetStrobe) begin
            chk("stray_packet_strobe", 64'd1, 64'd0);
        end
        if (cycleStrobe) begin
            if (cq.size() == 0) begin
                chk("spurious_cycle_strobe", 64'd1, 64'd0);
            end else begin
                ce = cq.pop_front();
                chk("cycle_time", 64'(cyc), 64'(ce.cyc));
                chk("cycle_count", 64'(cyclePacketCount), 64'(ce.cnt));
                chk("cycle_map", 64'(cycleIndexMap), 64'(ce.map));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[8];
    initial begin
        bit a;
        logic [4:0]  ridx;
        logic [31:0] rhdr;

        tbl[0] = '{32'hB6CF_1400, 1, 32'h01CA_CA01, ST_OK,        5'd5};
        tbl[1] = '{32'hDEAD_1400, 2, 32'h1111_1111, ST_BAD_MAGIC, 5'd5};
        tbl[2] = '{32'hB6CF_1400, 1, 32'h1234_5678, ST_OK,        5'd5};
        tbl[3] = '{32'hB6CF_0800, 0, 32'h0000_0000, ST_SHORT,     5'd2};
        tbl[4] = '{32'hB6CF_0C00, 3, 32'hAAAA_5555, ST_LONG,      5'd3};
        tbl[5] = '{32'hB6CF_7C00, 1, 32'hFFFF_0000, ST_OK,        5'd31};
        tbl[6] = '{32'hDEAD_0000, 0, 32'h0000_0000, ST_BAD_MAGIC, 5'd0};
        tbl[7] = '{32'hB6CF_0000, 1, 32'h0000_0001, ST_OK,        5'd0};

        rst_n = 0; nc = 0; tvalid = 0; tlast = 0; tdata = '0; magic = MAGIC;
        idle(3);
        chk("rst_tready",        64'(tready), 64'd0);
        chk("rst_statusStrobe",  64'(statusStrobe), 64'd0);
        chk("rst_statusCode",    64'(statusCode), 64'd0);
        chk("rst_packetStrobe",  64'(packetStrobe), 64'd0);
        chk("rst_packetIndex",   64'(packetIndex), 64'd0);
        chk("rst_packetData",    64'(packetData), 64'd0);
        chk("rst_cycleStrobe",   64'(cycleStrobe), 64'd0);
        chk("rst_cycleCount",    64'(cyclePacketCount), 64'd0);
        chk("rst_cycleMap",      64'(cycleIndexMap), 64'd0);
        rst_n = 1;
        idle(1);
        chk("tready_after_reset", 64'(tready), 64'd1);
        nc_pending = 1;
        idle(2);

        // Framing table, back to back with no idle cycles in between.
        for (int i = 0; i < 8; i++)
            send_packet(tbl[i].hdr, tbl[i].ndata, tbl[i].d0, tbl[i].code, tbl[i].idx, 0, 0);
        idle(3);
        nc_pending = 1;
        idle(2);

        // Eight good packets then a boundary, then an empty cycle.
        for (int i = 0; i < 8; i++)
            send_packet({MAGIC, 1'b0, 5'(i), 10'h155}, N, 32'hC0DE_0000 + i, ST_OK, 5'(i), 0, 0);
        idle(2);
        nc_pending = 1;
        idle(4);
        nc_pending = 1;
        idle(3);

        // Boundary on the TLAST beat: packet falls in the next cycle.
        send_packet({MAGIC, 6'd9, 10'd0}, N, 32'h0909_0909, ST_OK, 5'd9, 0, 1);
        idle(3);
        nc_pending = 1;
        idle(2);
        // Boundary one cycle after TLAST (with the packet strobe): packet stays in the closing cycle.
        send_packet({MAGIC, 6'd12, 10'd0}, N, 32'h0C0C_0C0C, ST_OK, 5'd12, 0, 0);
        nc_pending = 1;
        idle(3);
        nc_pending = 1;
        idle(2);

        // Reset with a header accepted and data outstanding.
        send_packet({MAGIC, 6'd7, 10'd0}, 3, 32'h7777_7777, ST_LONG, 5'd7, 0, 0);
        tvalid = 1; tlast = 0; tdata = {MAGIC, 6'd21, 10'd0};
        step(0, 5'd0, a);
        tvalid = 0;
        rst_n = 0;
        step(0, 5'd0, a);
        chk("tready_mid_reset", 64'(tready), 64'd0);
        m_cnt = 0;
        m_map = '0;
        step(0, 5'd0, a);
        chk("tready_mid_reset2", 64'(tready), 64'd0);
        rst_n = 1;
        step(0, 5'd0, a);
        chk("tready_recovered", 64'(tready), 64'd1);
        send_packet({MAGIC, 6'd17, 10'd3}, N, 32'h1717_1717, ST_OK, 5'd17, 0, 0);
        idle(2);

        // 100 good packets with 50% TVALID gaps; the tally saturates at 63.
        for (int i = 0; i < 100; i++) begin
            ridx = 5'($urandom());
            rhdr = {MAGIC, 1'($urandom()), ridx, 10'($urandom())};
            send_packet(rhdr, N, $urandom(), ST_OK, ridx, 50, 0);
        end
        idle(3);
        nc_pending = 1;
        idle(5);

        chk("status_queue_drained", 64'(sq.size()), 64'd0);
        chk("cycle_queue_drained",  64'(cq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmps_link_rx.md
# fmps_link_rx

Receive side of the FMPS test link. It consumes the 32-bit AXI-Stream produced by the FMPS test-link writer on the Aurora user clock, framed as one header beat followed by NUM_DATA_WORDS data beats. It validates the framing and the header magic, and delivers each good packet as a single-cycle strobe with its index and data. Per FA cycle it also tallies the good packets received and the indices seen, for the cell-controller test logic.

## Interface
- MAGIC_WIDTH, 16, header magic field width
- MAGIC_START_BIT, 16, LSB position of the magic in the header beat
- INDEX_WIDTH, 5, packet index field width
- INDEX_START_BIT, 10, LSB position of the index in the header beat
- NUM_DATA_WORDS, 1, data beats per packet; legal range 1..8
- auroraUserClk  in  1  sole clock
- auroraReset_n  in  1  synchronous, active-low reset
- newCycleStrobe  in  1  FA cycle boundary, single-cycle pulse
- expectedHeaderMagic  in  MAGIC_WIDTH  required value of the header magic field
- TVALID / TLAST / TDATA  in  1/1/32  AXI-Stream slave
- TREADY  out  1  stream ready
- statusStrobe  out  1  one pulse per packet terminated
- statusCode  out  2  0 OK, 1 bad magic, 2 short packet, 3 long packet
- packetStrobe  out  1  good packet delivered
- packetIndex  out  INDEX_WIDTH  header index of the delivered packet
- packetData  out  32*NUM_DATA_WORDS  data words; first beat in bits [31:0]
- cycleStrobe  out  1  per-cycle summary valid
- cyclePacketCount  out  INDEX_WIDTH+1  good packets in the closed cycle, saturating
- cycleIndexMap  out  2**INDEX_WIDTH  bit i set if index i was received in the closed cycle

## Operation
- A beat is accepted when TVALID and TREADY are both high. TREADY is registered: 0 in reset, 1 from the first cycle after auroraReset_n is released, and held at 1 thereafter.
- FSM states: HEADER, DATA, DRAIN. Reset state is HEADER.
- HEADER, on an accepted beat:
  - Latch the index.
  - If the magic field differs from expectedHeaderMagic: report code 1. If TLAST is high, stay in HEADER; otherwise go to DRAIN.
  - Else if TLAST is high: report code 2 and stay in HEADER.
  - Else: go to DATA with the word count at 0.
- DATA, on an accepted beat:
  - Store the beat at word slot count, then increment count.
  - If TLAST is high and count+1 < N: report code 2, go to HEADER.
  - If TLAST is high and count+1 == N: report code 0, pulse packetStrobe, go to HEADER.
  - If TLAST is low and count+1 == N: report code 3, go to DRAIN.
- DRAIN: discard beats until a TLAST beat is accepted, then go to HEADER. No further status is reported for the drained beats.
- Exactly one statusStrobe is issued per terminated packet. packetData and packetIndex hold their values until the next good packet.
- Cycle tally (counts good packets only):
  - On newCycleStrobe: pulse cycleStrobe with the current count and map, then clear both.
  - If a good packet completes in the same cycle as newCycleStrobe, it is counted in the new cycle.
  - Duplicate indices still increment the count; their map bit remains set.
  - The count saturates at 2**(INDEX_WIDTH+1)-1.
- newCycleStrobe never affects the framing FSM. A packet that spans a cycle boundary completes normally.
- Reset mid-packet: the FSM returns to HEADER and the partial packet is discarded without status.

## Timing
- statusStrobe, statusCode, packetStrobe, packetIndex and packetData are registered and appear 1 cycle after the terminating beat is accepted.
- cycleStrobe and its outputs are registered and appear 1 cycle after newCycleStrobe.
- Reset values: every strobe 0; statusCode 0; packetIndex 0; packetData 0; cyclePacketCount 0; cycleIndexMap 0; TREADY 0.
- Throughput: one beat per cycle. Back-to-back packets are accepted with no idle cycles between them.

## Structure
- Package fmps_link_pkg holds:
  - the status code constants (ST_OK, ST_BAD_MAGIC, ST_SHORT, ST_LONG);
  - the FSM state encoding;
  - the default field positions and widths.
- Sub-module fmps_cycle_tally holds the count, the index map and the newCycleStrobe snapshot. It takes packetStrobe and packetIndex as inputs.

## Test plan
- Header 0xB6CF_1400 then data 0x01CA_CA01 with TLAST, magic 0xB6CF -> status 0 and packetStrobe with index 5 and data 0x01CACA01, one cycle after the TLAST beat.
- Header with magic 0xDEAD followed by 2 beats, TLAST on the second -> exactly one status with code 1, no packetStrobe, and the next good packet is accepted.
- Header with TLAST -> code 2. With N=1, header plus 3 data beats, TLAST on the last -> code 3, drain to TLAST, then recovery.
- Eight good packets, indices 0..7, then newCycleStrobe -> cycleStrobe with count 8 and map 0x000000FF. The following cycle with no traffic reports count 0 and map 0.
- newCycleStrobe in the same cycle as a good packet's TLAST -> the packet is counted in the next cycle's summary. auroraReset_n low mid-packet -> no status, and TREADY is 0 during reset.
- Random TVALID gaps (50%) across 100 packets -> all delivered in order, with statusCode 0 throughout.
